ahb_txn_fifo: RTL

Synthesizable, parametrised FIFO of AHB-Lite transfer descriptors (hwrite, hsize, haddr, hdata) sitting between the testbench/master command source and the AHB-Lite master FSM. It replaces the dynamic-array transaction queue with fixed-depth circular storage, a valid/ready handshake on both sides, occupancy reporting, almost-full and overflow signalling, and synchronous flush. Output is first-word-fall-through: the head entry is always presented while `out_valid` is high.

---
 rtl/ahb_txn_fifo.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ahb_txn_fifo.sv
// Fixed-depth FWFT FIFO of AHB-Lite transfer descriptors (hwrite, hsize, haddr, hdata).
// Optional AHB_FIFO_BYPASS_EN: zero-latency pass-through when the FIFO is empty.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif

module ahb_txn_fifo #(
  parameter int unsigned BUS_WIDTH = `BUS_WIDTH,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_LEVEL  = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_write,
  input  logic [2:0]             in_size,
  input  logic [BUS_WIDTH-1:0]   in_addr,
  input  logic [BUS_WIDTH-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_write,
  output logic [2:0]             out_size,
  output logic [BUS_WIDTH-1:0]   out_addr,
  output logic [BUS_WIDTH-1:0]   out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = 2 * BUS_WIDTH + 4;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;
  logic          bypass_c;
  logic          push_fire_c;
  logic          pop_fire_c;
  logic [EW-1:0] head_c;

  // Descriptor taken straight from input to output without touching storage
`ifdef AHB_FIFO_BYPASS_EN
  assign bypass_c = empty_q & in_valid & out_ready;
`else
  assign bypass_c = 1'b0;
`endif

  assign push_fire_c = in_valid & ~full_q & ~bypass_c;
  assign pop_fire_c  = out_ready & ~empty_q;

  // Pointer and status next-state; status is derived from the next pointers
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_fire_c) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_fire_c)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (in_valid && full_q) ovf_d = 1'b1;
    end
    count_d = wr_ptr_d - rd_ptr_d;
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
    af_d    = (count_d >= PW'(AF_LEVEL));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is intentionally not cleared by reset or flush
  always_ff @(posedge clk) begin
    if (push_fire_c && !flush && !reset) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_write, in_size, in_addr, in_data};
    end
  end

  assign head_c = mem_q[rd_ptr_q[AW-1:0]];

`ifdef AHB_FIFO_BYPASS_EN
  always_comb begin
    out_valid = ~empty_q;
    {out_write, out_size, out_addr, out_data} = head_c;
    if (empty_q && in_valid) begin
      out_valid = 1'b1;
      {out_write, out_size, out_addr, out_data} = {in_write, in_size, in_addr, in_data};
    end
  end
`else
  assign out_valid = ~empty_q;
  assign {out_write, out_size, out_addr, out_data} = head_c;
`endif

  assign in_ready    = ~full_q;
  assign count       = count_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = af_q;
  assign overflow    = ovf_q;

endmodule
